addsub_seq: RTL and testbench

Parametrised multi-cycle two's-complement adder/subtractor, successor to the 4-bit ripple add/sub. It processes WIDTH-bit operands CHUNK bits per cycle, with a registered carry between chunks, so wide datapaths close timing without a full-width ripple chain. It has valid/ready handshakes on input and output, and reports carry-out, signed overflow and zero flags. It sits between operand-fetch logic and the result writeback stage in the datapath.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_if.sv | 31 +++
 rtl/addsub_chunk.sv | 28 ++
 rtl/addsub_seq.sv | 107 ++++++++++
 tb/tb_addsub_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunked add/sub unit.
// Holds the FSM state encoding and the op codes.
package addsub_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_seq.
// master drives operands and out_ready; slave is the unit.
interface addsub_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result,
      input  cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result,
      output cout, ovf, zero
   );

endinterface

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple of full adders.
// Ports: a, b, cin in; sum, cout, c_msb_in (carry into top bit) out.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] cy;

   always_comb begin
      cy    = '0;
      cy[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
   end

   assign sum      = a ^ b ^ cy[CHUNK-1:0];
   assign cout     = cy[CHUNK];
   assign c_msb_in = cy[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, CHUNK bits per cycle with a registered carry.
// Ports: clk, rst (sync, active high); bus = addsub_if slave.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic     clk,
   input logic     rst,
   addsub_if.slave bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
      $error("addsub_seq: bad WIDTH/CHUNK");
   end

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_nx;
   logic [KW-1:0]    k;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             last;
   logic             accept;

   logic [CHUNK-1:0] c_sum;
   logic             c_cout;
   logic             c_msb;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_q[int'(k)*CHUNK +: CHUNK]),
      .b        (b_q[int'(k)*CHUNK +: CHUNK]),
      .cin      (carry),
      .sum      (c_sum),
      .cout     (c_cout),
      .c_msb_in (c_msb)
   );

   assign last   = (k == KW'(NCHUNK - 1));
   assign accept = (state == S_IDLE) && bus.in_valid;

   // Full result as it will look after this chunk; zero uses it
   always_comb begin
      res_nx = res_q;
      res_nx[int'(k)*CHUNK +: CHUNK] = c_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (1'b1)
         state == S_IDLE: if (bus.in_valid)  state_nx = S_RUN;
         state == S_RUN:  if (last)          state_nx = S_DONE;
         state == S_DONE: if (bus.out_ready) state_nx = S_IDLE;
         default:         state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         k      <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         // Subtract as A + ~B + 1; the +1 rides in on the carry
         b_q   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
         carry <= bus.op;
         k     <= '0;
      end else if (state == S_RUN) begin
         res_q <= res_nx;
         carry <= c_cout;
         k     <= k + 1'b1;
         if (last) begin
            cout_q <= c_cout;
            ovf_q  <= c_cout ^ c_msb;
            zero_q <= (res_nx == '0);
         end
      end
   end

   assign bus.in_ready  = (state == S_IDLE) && !rst;
   assign bus.out_valid = (state == S_DONE);
   assign bus.result    = res_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed and random cases
// on 8/2, 16/16 and 16/4 configurations against an arithmetic model.
module tb_addsub_seq;

   typedef struct packed {
      logic        in_ready;
      logic        out_valid;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic [15:0] result;
   } obs_t;

   typedef struct packed {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   addsub_if #(.WIDTH(8))  i8 ();
   addsub_if #(.WIDTH(16)) i16 ();
   addsub_if #(.WIDTH(16)) i4 ();

   addsub_seq #(.WIDTH(8), .CHUNK(2)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (i8.slave)
   );

   addsub_seq #(.WIDTH(16), .CHUNK(16)) u16 (
      .clk (clk),
      .rst (rst),
      .bus (i16.slave)
   );

   addsub_seq #(.WIDTH(16), .CHUNK(4)) u4 (
      .clk (clk),
      .rst (rst),
      .bus (i4.slave)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int wd(input int sel);
      return (sel == 0) ? 8 : 16;
   endfunction

   function automatic int nch(input int sel);
      return (sel == 1) ? 1 : 4;
   endfunction

   // Plain integer arithmetic, unsigned and signed views
   function automatic exp_t model(input int w,
                                  input logic [15:0] a,
                                  input logic [15:0] b,
                                  input logic op);
      exp_t  r;
      longint m  = longint'(1) << w;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint ur = op ? ua - ub : ua + ub;
      longint sr = op ? sa - sb : sa + sb;
      r.res  = 16'(((ur % m) + m) % m);
      r.cout = op ? (ua >= ub) : (ur >= m);
      r.ovf  = (sr >= m / 2) || (sr < -(m / 2));
      r.zero = (r.res == 16'd0);
      return r;
   endfunction

   function automatic obs_t get(input int sel);
      obs_t o;
      o = '0;
      case (sel)
         0: begin
            o.in_ready  = i8.in_ready;
            o.out_valid = i8.out_valid;
            o.cout      = i8.cout;
            o.ovf       = i8.ovf;
            o.zero      = i8.zero;
            o.result    = {8'd0, i8.result};
         end
         1: begin
            o.in_ready  = i16.in_ready;
            o.out_valid = i16.out_valid;
            o.cout      = i16.cout;
            o.ovf       = i16.ovf;
            o.zero      = i16.zero;
            o.result    = i16.result;
         end
         default: begin
            o.in_ready  = i4.in_ready;
            o.out_valid = i4.out_valid;
            o.cout      = i4.cout;
            o.ovf       = i4.ovf;
            o.zero      = i4.zero;
            o.result    = i4.result;
         end
      endcase
      return o;
   endfunction

   task automatic drive(input int sel, input logic v,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic op, input logic ordy);
      case (sel)
         0: begin
            i8.in_valid  = v;
            i8.a         = a[7:0];
            i8.b         = b[7:0];
            i8.op        = op;
            i8.out_ready = ordy;
         end
         1: begin
            i16.in_valid  = v;
            i16.a         = a;
            i16.b         = b;
            i16.op        = op;
            i16.out_ready = ordy;
         end
         default: begin
            i4.in_valid  = v;
            i4.a         = a;
            i4.b         = b;
            i4.op        = op;
            i4.out_ready = ordy;
         end
      endcase
   endtask

   task automatic run_op(input int sel,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic op, input int hold);
      exp_t e;
      obs_t o;
      obs_t o0;
      int   n;
      int   lat;
      e = model(wd(sel), a, b, op);
      n = 0;
      while (!get(sel).in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("rdy_wait", 32'(n < 50), 32'd1);
      drive(sel, 1'b1, a, b, op, 1'b0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      lat = 0;
      while (!get(sel).out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(nch(sel)));
      o0 = get(sel);
      check("result", 32'(o0.result), 32'(e.res));
      check("cout", 32'(o0.cout), 32'(e.cout));
      check("ovf", 32'(o0.ovf), 32'(e.ovf));
      check("zero", 32'(o0.zero), 32'(e.zero));
      for (int h = 0; h < hold; h++) begin
         drive(sel, 1'b1, 16'($urandom), 16'($urandom),
               1'($urandom), 1'b0);
         @(posedge clk); #1;
         o = get(sel);
         check("hold_obs", 32'(o), 32'(o0));
         check("hold_rdy", 32'(o.in_ready), 32'd0);
      end
      drive(sel, hold > 0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(sel, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      o = get(sel);
      check("post_rdy", 32'(o.in_ready), 32'd1);
      check("post_ov", 32'(o.out_valid), 32'd0);
   endtask

   initial begin
      obs_t o;
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] msk;
      for (int s = 0; s < 3; s++) begin
         drive(s, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      o = get(0);
      check("rst_rdy", 32'(o.in_ready), 32'd0);
      check("rst_obs", 32'(o), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_rdy1", 32'(get(0).in_ready), 32'd1);

      run_op(0, 16'h7F, 16'h01, 1'b0, 0);
      run_op(0, 16'h05, 16'h07, 1'b1, 0);
      run_op(0, 16'h80, 16'h01, 1'b1, 0);
      run_op(0, 16'h10, 16'h10, 1'b1, 0);
      run_op(0, 16'h3C, 16'h15, 1'b0, 5);
      run_op(0, 16'h22, 16'h11, 1'b1, 0);

      // Reset in the middle of a run
      drive(0, 1'b1, 16'hFF, 16'h01, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      o = get(0);
      check("mid_rdy", 32'(o.in_ready), 32'd1);
      o.in_ready = 1'b0;
      check("mid_obs", 32'(o), 32'd0);
      repeat (6) begin
         @(posedge clk); #1;
      end
      check("mid_quiet", 32'(get(0).out_valid), 32'd0);
      run_op(0, 16'h01, 16'h01, 1'b0, 0);

      run_op(1, 16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(2, 16'h8000, 16'h0001, 1'b1, 2);

      for (int s = 0; s < 3; s++) begin
         msk = (s == 0) ? 16'h00FF : 16'hFFFF;
         for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom) & msk;
            rb = 16'($urandom) & msk;
            if (i % 8 == 0) rb = ra;
            run_op(s, ra, rb, 1'($urandom),
                   int'($urandom_range(0, 2)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
